// File: rtl/trap_controller.sv
// trap_controller: sequences ECALL/misaligned/MRET CSR updates and EBREAK debug halt, then redirects the PC.
module trap_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        trapped,
  input  logic [1:0]  trap_status,
  input  logic [31:0] pc,
  input  logic [31:0] csr_read_data,
  input  logic        debug_continue,
  output logic        pc_stall,
  output logic        csr_write_enable,
  output logic [11:0] csr_trap_address,
  output logic [31:0] csr_trap_write_data,
  output logic [31:0] trap_target,
  output logic        trap_done,
  output logic        debug_mode
);
  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WRITE_MEPC   = 3'd1;
  localparam logic [2:0] WRITE_MCAUSE = 3'd2;
  localparam logic [2:0] READ_MTVEC   = 3'd3;
  localparam logic [2:0] GOTO_MTVEC   = 3'd4;
  localparam logic [2:0] READ_MEPC    = 3'd5;
  localparam logic [2:0] GOTO_MEPC    = 3'd6;
  localparam logic [2:0] DEBUG        = 3'd7;
  logic [2:0]  state, next_state;
  logic [1:0]  cap_status;
  logic [31:0] cap_pc, mtvec, mepc;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:         next_state = !trapped ? IDLE :
                                 trap_status == 2'b01 ? DEBUG :
                                 trap_status == 2'b11 ? READ_MEPC : WRITE_MEPC;
      WRITE_MEPC:   next_state = WRITE_MCAUSE;
      WRITE_MCAUSE: next_state = READ_MTVEC;
      READ_MTVEC:   next_state = GOTO_MTVEC;
      READ_MEPC:    next_state = GOTO_MEPC;
      DEBUG:        next_state = debug_continue ? IDLE : DEBUG;
      default:      next_state = IDLE;
    endcase
  end
  // Outputs are forced low while reset is held, regardless of state.
  always_comb begin
    pc_stall            = 1'b0;
    csr_write_enable    = 1'b0;
    csr_trap_address    = 12'h000;
    csr_trap_write_data = 32'd0;
    trap_target         = 32'd0;
    trap_done           = 1'b0;
    debug_mode          = 1'b0;
    if (reset) begin
      case (state)
        IDLE: pc_stall = trapped;
        WRITE_MEPC: begin
          pc_stall            = 1'b1;
          csr_write_enable    = 1'b1;
          csr_trap_address    = 12'h341;
          csr_trap_write_data = cap_pc;
        end
        WRITE_MCAUSE: begin
          pc_stall            = 1'b1;
          csr_write_enable    = 1'b1;
          csr_trap_address    = 12'h342;
          csr_trap_write_data = cap_status == 2'b00 ? 32'd11 : 32'd0;
        end
        READ_MTVEC: begin
          pc_stall         = 1'b1;
          csr_trap_address = 12'h305;
        end
        GOTO_MTVEC: begin
          trap_done   = 1'b1;
          trap_target = mtvec;
        end
        READ_MEPC: begin
          pc_stall         = 1'b1;
          csr_trap_address = 12'h341;
        end
        GOTO_MEPC: begin
          trap_done   = 1'b1;
          trap_target = mepc;
        end
        DEBUG: begin
          pc_stall    = 1'b1;
          debug_mode  = 1'b1;
          trap_done   = debug_continue;
          trap_target = debug_continue ? cap_pc + 32'd4 : 32'd0;
        end
        default: pc_stall = 1'b0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cap_pc     <= 32'd0;
      cap_status <= 2'b00;
      mtvec      <= 32'd0;
      mepc       <= 32'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && trapped) begin
        cap_pc     <= pc;
        cap_status <= trap_status;
      end
      if (state == READ_MTVEC) mtvec <= {csr_read_data[31:2], 2'b00};
      if (state == READ_MEPC) mepc <= csr_read_data;
    end
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: table-driven vectors plus hand sequences for debug, reset abort and back-to-back traps.
module tb_trap_controller;
  logic        clk = 1'b0;
  logic        reset, trapped, debug_continue;
  logic [1:0]  trap_status;
  logic [31:0] pc, csr_read_data;
  logic        pc_stall, csr_write_enable, trap_done, debug_mode;
  logic [11:0] csr_trap_address;
  logic [31:0] csr_trap_write_data, trap_target;
  int total = 0, bad = 0;

  trap_controller dut (
    .clk(clk), .reset(reset), .trapped(trapped), .trap_status(trap_status), .pc(pc),
    .csr_read_data(csr_read_data), .debug_continue(debug_continue), .pc_stall(pc_stall),
    .csr_write_enable(csr_write_enable), .csr_trap_address(csr_trap_address),
    .csr_trap_write_data(csr_trap_write_data), .trap_target(trap_target),
    .trap_done(trap_done), .debug_mode(debug_mode)
  );

  always #5 clk = ~clk;

  logic [79:0] outv;
  assign outv = {pc_stall, csr_write_enable, csr_trap_address, csr_trap_write_data,
                 trap_target, trap_done, debug_mode};

  typedef struct {
    logic        r, tr, dc;
    logic [1:0]  st;
    logic [31:0] p, rd;
    logic [79:0] ex;
  } vec_t;

  function automatic logic [79:0] e(input logic s, input logic w, input logic [11:0] a,
                                    input logic [31:0] d, input logic [31:0] t,
                                    input logic dn, input logic dm);
    return {s, w, a, d, t, dn, dm};
  endfunction

  function automatic vec_t v(input logic r, input logic tr, input logic [1:0] st,
                             input logic [31:0] p, input logic [31:0] rd, input logic dc,
                             input logic [79:0] ex);
    vec_t x;
    x.r = r; x.tr = tr; x.st = st; x.p = p; x.rd = rd; x.dc = dc; x.ex = ex;
    return x;
  endfunction

  // Drive just after a rising edge, sample on the following falling edge.
  task automatic drive(input logic r, input logic tr, input logic [1:0] st,
                       input logic [31:0] p, input logic [31:0] rd, input logic dc);
    @(posedge clk);
    #1;
    reset = r; trapped = tr; trap_status = st; pc = p; csr_read_data = rd; debug_continue = dc;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [79:0] ex);
    total++;
    if (outv !== ex) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (stall,we,addr,wdata,target,done,dbg)", nm, outv, ex);
    end
  endtask

  localparam logic [79:0] Z = 80'd0;
  vec_t tbl[17];

  initial begin
    reset = 1'b0; trapped = 1'b0; trap_status = 2'b00; pc = 32'd0;
    csr_read_data = 32'd0; debug_continue = 1'b0;
    tbl[0]  = v(0, 1, 2'b00, 32'h100, 0, 0, Z);
    tbl[1]  = v(0, 0, 2'b00, 32'h0,   0, 0, Z);
    tbl[2]  = v(1, 1, 2'b00, 32'h100, 0, 0, e(1, 0, 12'h000, 0, 0, 0, 0));
    tbl[3]  = v(1, 0, 2'b00, 32'h0,   0, 0, e(1, 1, 12'h341, 32'h100, 0, 0, 0));
    tbl[4]  = v(1, 0, 2'b00, 32'h0,   0, 0, e(1, 1, 12'h342, 32'd11, 0, 0, 0));
    tbl[5]  = v(1, 0, 2'b00, 32'h0, 32'h203, 0, e(1, 0, 12'h305, 0, 0, 0, 0));
    tbl[6]  = v(1, 0, 2'b00, 32'h0,   0, 0, e(0, 0, 12'h000, 0, 32'h200, 1, 0));
    tbl[7]  = v(1, 0, 2'b00, 32'h0,   0, 0, Z);
    tbl[8]  = v(1, 1, 2'b10, 32'hF0,  0, 0, e(1, 0, 12'h000, 0, 0, 0, 0));
    tbl[9]  = v(1, 0, 2'b00, 32'h0,   0, 0, e(1, 1, 12'h341, 32'hF0, 0, 0, 0));
    tbl[10] = v(1, 0, 2'b00, 32'h0,   0, 0, e(1, 1, 12'h342, 32'd0, 0, 0, 0));
    tbl[11] = v(1, 0, 2'b00, 32'h0, 32'h1001, 0, e(1, 0, 12'h305, 0, 0, 0, 0));
    tbl[12] = v(1, 0, 2'b00, 32'h0,   0, 0, e(0, 0, 12'h000, 0, 32'h1000, 1, 0));
    tbl[13] = v(1, 1, 2'b11, 32'h500, 0, 0, e(1, 0, 12'h000, 0, 0, 0, 0));
    tbl[14] = v(1, 0, 2'b00, 32'h0, 32'h1234, 0, e(1, 0, 12'h341, 0, 0, 0, 0));
    tbl[15] = v(1, 0, 2'b00, 32'h0,   0, 0, e(0, 0, 12'h000, 0, 32'h1234, 1, 0));
    tbl[16] = v(1, 0, 2'b00, 32'h0,   0, 1, Z);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].tr, tbl[i].st, tbl[i].p, tbl[i].rd, tbl[i].dc);
      chk($sformatf("vec%0d", i), tbl[i].ex);
    end

    // EBREAK: halt for 10 cycles, release, then debug_mode drops
    drive(1, 1, 2'b01, 32'h40, 0, 0);
    chk("ebreak_entry", e(1, 0, 12'h000, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 2'b00, 32'h0, 0, 0);
      chk($sformatf("debug_hold%0d", i), e(1, 0, 12'h000, 0, 0, 0, 1));
    end
    drive(1, 0, 2'b00, 32'h0, 0, 1);
    chk("debug_release", e(1, 0, 12'h000, 0, 32'h44, 1, 1));
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    chk("debug_exit", Z);

    // Reset while in DEBUG aborts without a trap_done
    drive(1, 1, 2'b01, 32'h80, 0, 0);
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    chk("debug_again", e(1, 0, 12'h000, 0, 0, 0, 1));
    drive(0, 0, 2'b00, 32'h0, 0, 1);
    chk("debug_reset", Z);
    drive(1, 0, 2'b00, 32'h0, 0, 1);
    chk("debug_reset_idle", Z);

    // Reset in WRITE_MCAUSE aborts, fresh ECALL completes at T+4
    drive(1, 1, 2'b00, 32'h100, 0, 0);
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    drive(0, 0, 2'b00, 32'h0, 0, 0);
    chk("mcause_reset", Z);
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    chk("mcause_reset_idle", Z);
    drive(1, 1, 2'b00, 32'h300, 0, 0);
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    chk("fresh_mepc", e(1, 1, 12'h341, 32'h300, 0, 0, 0));
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    drive(1, 0, 2'b00, 32'h0, 32'h400, 0);
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    chk("fresh_done", e(0, 0, 12'h000, 0, 32'h400, 1, 0));

    // trapped held high: no re-capture mid-sequence, new sequence right after GOTO
    drive(1, 1, 2'b00, 32'h100, 0, 0);
    drive(1, 1, 2'b11, 32'h999, 0, 0);
    chk("held_mepc", e(1, 1, 12'h341, 32'h100, 0, 0, 0));
    drive(1, 1, 2'b11, 32'h999, 0, 0);
    chk("held_mcause", e(1, 1, 12'h342, 32'd11, 0, 0, 0));
    drive(1, 1, 2'b11, 32'h999, 32'h300, 0);
    drive(1, 1, 2'b11, 32'h999, 0, 0);
    chk("held_goto", e(0, 0, 12'h000, 0, 32'h300, 1, 0));
    drive(1, 1, 2'b00, 32'h200, 0, 0);
    chk("held_idle2", e(1, 0, 12'h000, 0, 0, 0, 0));
    drive(1, 0, 2'b00, 32'h0, 0, 0);
    chk("held_second", e(1, 1, 12'h341, 32'h200, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
